// File: rtl/blade_emitter.sv
// Blade length ramp for the lightsaber: captures a sanitised target length and
// grows/shrinks the visible blade toward it in timed centimetre steps.
module blade_emitter #(
    parameter int STEP_CM  = 1,
    parameter int STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] setL,
    input  logic [15:0] setR,
    input  logic        ignite,
    output logic [15:0] curL,
    output logic [15:0] curR,
    output logic [1:0]  state,
    output logic        lit,
    output logic        at_length
);

    localparam int             DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [7:0]     STEP     = 8'(STEP_CM);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_EXTEND  = 2'd1,
        ST_LIT     = 2'd2,
        ST_RETRACT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         cm_q, cm_d;
    logic [6:0]         target_q, target_d;
    logic [DIV_W-1:0]   div_q, div_d;

    logic [6:0] san;
    logic [6:0] nt;
    logic [6:0] g;
    logic       tick;
    logic [7:0] up_sum;
    logic [6:0] up_val;
    logic [6:0] dn_val;

    // Negative requests fall back to half length; anything past 1.00 m clamps.
    always_comb begin
        san = 7'd0;
        if (setL[15] || setR[15]) begin
            san = 7'd50;
        end else if (setL >= 16'd2 || setR >= 16'd100 || (setL == 16'd1 && setR != 16'd0)) begin
            san = 7'd100;
        end else if (setL[0]) begin
            san = 7'd100;
        end else begin
            san = setR[6:0];
        end
    end

    assign nt     = load ? san : target_q;
    assign g      = ignite ? nt : 7'd0;
    assign tick   = (div_q == DIV_LAST);
    assign up_sum = {1'b0, cm_q} + STEP;
    assign up_val = (up_sum >= {1'b0, g}) ? g : up_sum[6:0];
    // Only consulted while retracting, where g < cm so the difference cannot wrap.
    assign dn_val = ({1'b0, cm_q - g} <= STEP) ? g : cm_q - STEP[6:0];

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cm_d     = cm_q;
        target_d = load ? san : target_q;
        div_d    = tick ? '0 : div_q + 1'b1;

        case (state_q)
            ST_OFF: begin
                cm_d = 7'd0;
                if (ignite && nt != 7'd0) state_d = ST_EXTEND;
            end
            ST_EXTEND: begin
                if (g < cm_q) begin
                    state_d = ST_RETRACT;
                end else if (g == cm_q) begin
                    state_d = (g == 7'd0) ? ST_OFF : ST_LIT;
                end else if (tick) begin
                    cm_d = up_val;
                    if (up_val == g) state_d = ST_LIT;
                end
            end
            ST_LIT: begin
                if (g > cm_q)      state_d = ST_EXTEND;
                else if (g < cm_q) state_d = ST_RETRACT;
            end
            ST_RETRACT: begin
                if (g > cm_q) begin
                    state_d = ST_EXTEND;
                end else if (g == cm_q) begin
                    state_d = (g == 7'd0) ? ST_OFF : ST_LIT;
                end else if (tick) begin
                    cm_d = dn_val;
                    if (dn_val == g) state_d = (g == 7'd0) ? ST_OFF : ST_LIT;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // A direction change or an idle state restarts the step cadence.
        if (state_d != state_q || state_q == ST_OFF || state_q == ST_LIT) div_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            cm_q     <= 7'd0;
            target_q <= 7'd100;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            cm_q     <= cm_d;
            target_q <= target_d;
            div_q    <= div_d;
        end
    end

    assign curL      = {15'd0, cm_q == 7'd100};
    assign curR      = (cm_q == 7'd100) ? 16'd0 : {9'd0, cm_q};
    assign state     = state_q;
    assign lit       = (state_q != ST_OFF);
    assign at_length = (state_q == ST_LIT);

endmodule
